mxv_t_nnbit_jkdim_relu_bwd: RTL and testbench
=============================================

Name: mxv_t_nnbit_jkdim_relu_bwd

Overview:
- Backward-pass counterpart of the fully-connected ReLU layer.
- Computes the input gradient g = Wᵀ·(delta ⊙ relu'(z)), where:
  - W is the J×K weight matrix used in the forward pass;
  - delta is the J-element output gradient;
  - relu'(z) is taken from the forward pre-activation sign bits.
- Sequential, row-serial MAC: one row of W per cycle, with K parallel multipliers.
- Sits after the forward FC layer in training/garbled-backprop datapaths.

Parameters:
- N, 8, signed bit-width of weights and delta elements.
- J, 3, rows of W (forward output count; number of backward MAC steps).
- K, 3, columns of W (forward input count; backward output count).
- L, 2*N+J-1, signed width of each output accumulator.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- g_input  input  J*K*N  signed W, row-major; W[j][k] = bits [(j*K+k+1)*N-1 -: N].
- e_delta  input  J*N  signed delta; delta[j] = bits [(j+1)*N-1 -: N].
- fwd_sign  input  J  bit j = sign bit of forward pre-activation j (1 = ReLU was inactive).
- busy  output  1  high while accumulating.
- o_valid  output  1  one-cycle pulse when o is updated.
- o  output  K*L  signed gradient; g[k] = bits [(k+1)*L-1 -: L].

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, busy=0, o_valid=0, o=0, accumulators=0, row counter=0. In-flight computation is discarded.
- States:
  - IDLE: busy=0, o_valid=0, o holds.
  - MAC: busy=1.
  - DONE: busy=0, o_valid=1 for exactly one cycle.
- Start accept: start=1 at edge t while state∈{IDLE, DONE}.
  - Registers g_input, e_delta and fwd_sign.
  - Masked delta md[j] = fwd_sign[j] ? 0 : delta[j].
  - Clears all K accumulators, row=0, state→MAC.
  - Inputs may change after edge t without effect.
- MAC, edges t+1 … t+J: on edge t+1+r, acc[k] += W[r][k]*md[r] for all k in parallel, then row++.
- Last row (edge t+J):
  - o ← final acc (acc + last product, written in the same edge);
  - o_valid=1; state→DONE.
- DONE: next edge goes to MAC if start=1 (back-to-back accepted), else to IDLE. o_valid drops unless a new result completes.
- Latency: result visible and o_valid high in the cycle after edge t+J, i.e. J cycles after start accept.
- start while busy=1: ignored, no queuing, no error flag.
- Arithmetic:
  - N×N signed product is 2N bits, sign-extended to L.
  - Sum of J products fits in L bits, so there is no overflow or saturation.
  - Two's-complement throughout.
- Masking matches the forward ReLU convention: gradient passes iff the sign bit is 0, including pre-activation == 0.
- o holds its last value between results; it changes only together with an o_valid pulse or on reset.
- J=1: MAC lasts one edge; o_valid one cycle after accept.

Decomposition:
- Package fc_bwd_pkg:
  - state enum {IDLE, MAC, DONE};
  - function for the row counter width ($clog2(J), minimum 1);
  - slice index helper functions for W/delta/g bit offsets.
- Sub-module mac_row_nnbit (params N, K, L):
  - combinational K parallel signed N×N multiplies by a shared scalar;
  - adds the products to the K accumulator inputs;
  - used once per cycle by the FSM.

Test Plan (N=8, J=3, K=3, L=18):
1. W rows [1,2,3],[4,5,6],[7,8,9]; delta=[1,1,1]; fwd_sign=000; start pulse -> busy 3 cycles; o_valid one cycle later; o=[12,15,18]; o stable afterwards.
2. Same W/delta, fwd_sign=010 -> o=[8,10,12]. Then fwd_sign=111 -> o=[0,0,0] with o_valid still pulsed.
3. All W=-128, delta=-128, fwd_sign=000 -> each g=49152. Then delta=127 -> each g=-48768; no wrap in 18 bits.
4. delta=[2,-3,1], W as test 1, fwd_sign=000 -> o=[-3,-3,-3]. Change inputs on the cycle after start -> result unchanged.
5. start held high continuously -> second job accepted in DONE cycle; o_valid pulses every 4 cycles. start while busy produces no extra o_valid.
6. Assert rst asynchronously (between edges) during MAC row 1 -> busy, o_valid, o drop to 0 immediately. Next start after release yields the correct full result.

Source files
------------

// File: rtl/fc_bwd_pkg.sv
// Shared types and slice helpers for the FC-layer backward (input-gradient) datapath.
package fc_bwd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Row counter width: enough to count J rows, never narrower than one bit.
  function automatic int row_w(input int j);
    return (j > 1) ? $clog2(j) : 1;
  endfunction

  // LSB of W[j][k] in the row-major packed weight bus.
  function automatic int w_lsb(input int j, input int k, input int kk, input int n);
    return (j * kk + k) * n;
  endfunction

  // LSB of delta[j] in the packed delta bus.
  function automatic int d_lsb(input int j, input int n);
    return j * n;
  endfunction

  // LSB of g[k] in the packed gradient / accumulator bus.
  function automatic int g_lsb(input int k, input int l);
    return k * l;
  endfunction

endpackage

// File: rtl/mac_row_nnbit.sv
// One backward MAC step: K signed weights times a shared signed scalar,
// each product sign-extended to L bits and added to its accumulator.
module mac_row_nnbit #(
  parameter int N = 8,
  parameter int K = 3,
  parameter int L = 18
) (
  input  logic [K*N-1:0] w_row,
  input  logic [N-1:0]   scalar,
  input  logic [K*L-1:0] acc_in,
  output logic [K*L-1:0] acc_out
);
  import fc_bwd_pkg::*;

  for (genvar k = 0; k < K; k++) begin : g_lane
    logic signed [N-1:0]   w_k;
    logic signed [N-1:0]   s_k;
    logic signed [2*N-1:0] prod;
    logic signed [L-1:0]   prod_ext;
    logic signed [L-1:0]   acc_k;

    assign w_k      = w_row[w_lsb(0, k, K, N) +: N];
    assign s_k      = scalar;
    // Operands widened first so the product keeps its full 2N-bit signed range.
    assign prod     = (2*N)'(w_k) * (2*N)'(s_k);
    assign prod_ext = L'(prod);
    assign acc_k    = acc_in[g_lsb(k, L) +: L];
    assign acc_out[g_lsb(k, L) +: L] = acc_k + prod_ext;
  end

endmodule

// File: rtl/mxv_t_nnbit_jkdim_relu_bwd.sv
// Backward pass of a ReLU fully-connected layer: g = W^T * (delta masked by relu'(z)).
// Row-serial: one row of W per cycle through K parallel multipliers.
//
// Handshake: start is a request that is accepted on any edge where busy=0
// (IDLE or DONE); inputs are captured on that edge and may change freely
// afterwards. start while busy=1 is dropped. Exactly J cycles after the
// accepting edge, o_valid is high for one cycle and o carries the result;
// o holds until the next o_valid pulse or reset.
module mxv_t_nnbit_jkdim_relu_bwd #(
  parameter int N = 8,
  parameter int J = 3,
  parameter int K = 3,
  parameter int L = 2*N + J - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [J*K*N-1:0] g_input,
  input  logic [J*N-1:0]   e_delta,
  input  logic [J-1:0]     fwd_sign,
  output logic             busy,
  output logic             o_valid,
  output logic [K*L-1:0]   o
);
  import fc_bwd_pkg::*;

  localparam int RW = row_w(J);

  state_t           state;
  state_t           state_nxt;
  logic [J*K*N-1:0] w_r;
  logic [J*N-1:0]   md_r;
  logic [J*N-1:0]   md_in;
  logic [K*L-1:0]   acc;
  logic [K*L-1:0]   acc_nxt;
  logic [K*L-1:0]   o_r;
  logic [RW-1:0]    row;
  logic [K*N-1:0]   w_row;
  logic [N-1:0]     md_row;
  logic             accept;
  logic             last_row;

  assign accept   = start && (state != MAC);
  assign last_row = (row == RW'(J - 1));
  assign w_row    = w_r[w_lsb(int'(row), 0, K, N) +: K*N];
  assign md_row   = md_r[d_lsb(int'(row), N) +: N];

  assign busy    = (state == MAC);
  assign o_valid = (state == DONE);
  assign o       = o_r;

  // Zero the delta of every inactive unit (sign bit set) before it is captured.
  always_comb begin
    md_in = '0;
    for (int j = 0; j < J; j++) begin
      md_in[d_lsb(j, N) +: N] = fwd_sign[j] ? '0 : e_delta[d_lsb(j, N) +: N];
    end
  end

  mac_row_nnbit #(.N(N), .K(K), .L(L)) u_mac (
    .w_row   (w_row),
    .scalar  (md_row),
    .acc_in  (acc),
    .acc_out (acc_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: DONE doubles as an accept slot so back-to-back jobs lose no cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (last_row) state_nxt = DONE;
      DONE:    state_nxt = start ? MAC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, row-serial accumulation, and result publish on the last row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_r  <= '0;
      md_r <= '0;
      acc  <= '0;
      row  <= '0;
      o_r  <= '0;
    end else if (accept) begin
      w_r  <= g_input;
      md_r <= md_in;
      acc  <= '0;
      row  <= '0;
    end else if (state == MAC) begin
      acc <= acc_nxt;
      row <= row + 1'b1;
      if (last_row) o_r <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_mxv_t_nnbit_jkdim_relu_bwd.sv
// Self-checking bench for the ReLU FC backward block (N=8, J=3, K=3, L=18).
module tb_mxv_t_nnbit_jkdim_relu_bwd;
  localparam int N = 8;
  localparam int J = 3;
  localparam int K = 3;
  localparam int L = 2*N + J - 1;
  localparam int GW = K*L;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [J*K*N-1:0] g_input;
  logic [J*N-1:0]   e_delta;
  logic [J-1:0]     fwd_sign;
  logic             busy;
  logic             o_valid;
  logic [K*L-1:0]   o;

  always #5 clk = ~clk;

  mxv_t_nnbit_jkdim_relu_bwd #(.N(N), .J(J), .K(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .g_input  (g_input),
    .e_delta  (e_delta),
    .fwd_sign (fwd_sign),
    .busy     (busy),
    .o_valid  (o_valid),
    .o        (o)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [GW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // g[k] = sum over active rows j of W[j][k]*delta[j], plain integer arithmetic.
  function automatic logic [GW-1:0] model(input logic [J*K*N-1:0] w,
                                          input logic [J*N-1:0] d,
                                          input logic [J-1:0] s);
    logic [GW-1:0] res;
    logic signed [N-1:0] wv;
    logic signed [N-1:0] dv;
    int sum;
    res = '0;
    for (int k = 0; k < K; k++) begin
      sum = 0;
      for (int j = 0; j < J; j++) begin
        wv = w[(j*K + k)*N +: N];
        dv = d[j*N +: N];
        if (s[j] == 1'b0) sum += int'(wv) * int'(dv);
      end
      res[k*L +: L] = sum[L-1:0];
    end
    return res;
  endfunction

  function automatic logic [J*K*N-1:0] pack_w(input int v[J*K]);
    logic [J*K*N-1:0] r;
    for (int i = 0; i < J*K; i++) r[i*N +: N] = v[i][N-1:0];
    return r;
  endfunction

  function automatic logic [J*N-1:0] pack_d(input int v[J]);
    logic [J*N-1:0] r;
    for (int i = 0; i < J; i++) r[i*N +: N] = v[i][N-1:0];
    return r;
  endfunction

  function automatic logic [GW-1:0] pack_g(input int v[K]);
    logic [GW-1:0] r;
    for (int i = 0; i < K; i++) r[i*L +: L] = v[i][L-1:0];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // One job: accept, J busy cycles, one o_valid cycle with the result, then o held.
  task automatic do_job(input logic [J*K*N-1:0] w, input logic [J*N-1:0] d,
                        input logic [J-1:0] s, input bit scramble, input string tag);
    logic [GW-1:0] e;
    e = model(w, d, s);
    @(negedge clk);
    g_input = w; e_delta = d; fwd_sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      g_input  = {$urandom, $urandom, $urandom};
      e_delta  = 24'($urandom);
      fwd_sign = 3'($urandom);
      start    = 1'b1;
    end
    for (int i = 0; i < J; i++) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_ov_lo"}, 64'(o_valid), 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    check({tag, "_ov"}, 64'(o_valid), 64'd1);
    check({tag, "_done_busy"}, 64'(busy), 64'd0);
    check({tag, "_o"}, 64'(o), 64'(e));
    @(posedge clk); #1;
    check({tag, "_ov_drop"}, 64'(o_valid), 64'd0);
    check({tag, "_o_hold"}, 64'(o), 64'(e));
  endtask

  int wv[J*K];
  int dv[J];
  int gv[K];
  logic [J*K*N-1:0] w1;
  logic [J*N-1:0]   d1;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; g_input = '0; e_delta = '0; fwd_sign = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ov", 64'(o_valid), 64'd0);
    check("rst_o", 64'(o), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Test 1: known matrix, all units active.
    wv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    dv = '{1, 1, 1};
    w1 = pack_w(wv); d1 = pack_d(dv);
    gv = '{12, 15, 18};
    check("t1_const_model", 64'(model(w1, d1, 3'b000)), 64'(pack_g(gv)));
    do_job(w1, d1, 3'b000, 1'b0, "t1");
    repeat (3) @(posedge clk);
    #1 check("t1_stable", 64'(o), 64'(pack_g(gv)));

    // Test 2: masked rows.
    do_job(w1, d1, 3'b010, 1'b0, "t2a");
    do_job(w1, d1, 3'b111, 1'b0, "t2b");

    // Test 3: extreme magnitudes.
    wv = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    dv = '{-128, -128, -128};
    gv = '{49152, 49152, 49152};
    check("t3_const_model", 64'(model(pack_w(wv), pack_d(dv), 3'b000)), 64'(pack_g(gv)));
    do_job(pack_w(wv), pack_d(dv), 3'b000, 1'b0, "t3a");
    dv = '{127, 127, 127};
    do_job(pack_w(wv), pack_d(dv), 3'b000, 1'b0, "t3b");

    // Test 4: mixed-sign delta, inputs scrambled after accept.
    dv = '{2, -3, 1};
    gv = '{-3, -3, -3};
    check("t4_const_model", 64'(model(w1, pack_d(dv), 3'b000)), 64'(pack_g(gv)));
    do_job(w1, pack_d(dv), 3'b000, 1'b1, "t4");

    // Test 5: start held high; accepts land every J+1 edges with new random operands.
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      g_input = {$urandom, $urandom, $urandom};
      e_delta = 24'($urandom);
      fwd_sign = 3'($urandom_range(0, 7));
      start = 1'b1;
      if (c % (J+1) == 0) exp_q.push_back(model(g_input, e_delta, fwd_sign));
      @(posedge clk); #1;
      check("t5_ov", 64'(o_valid), 64'(c % (J+1) == J));
      if (c % (J+1) == J) begin
        if (exp_q.size() == 0) check("t5_q_empty", 64'd1, 64'd0);
        else check("t5_o", 64'(o), 64'(exp_q.pop_front()));
      end
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("t5_idle", 64'(busy), 64'd0);

    // Test 6: asynchronous reset during MAC row 1.
    do_job(w1, d1, 3'b000, 1'b0, "t6pre");
    @(negedge clk);
    g_input = w1; e_delta = d1; fwd_sign = 3'b000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_ov", 64'(o_valid), 64'd0);
    check("t6_o", 64'(o), 64'd0);
    @(negedge clk); rst = 1'b0;
    do_job(w1, d1, 3'b000, 1'b0, "t6post");

    // Random jobs against the model.
    for (int n = 0; n < 20; n++) begin
      do_job({$urandom, $urandom, $urandom}, 24'($urandom), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
